// File: rtl/fpu_chk_pkg.sv
// -----------------------------------------------------------------------------
// fpu_chk_pkg
// Shared types and constants for the FPU vector checker.
//   state_e   : checker FSM states (IDLE, WAIT, CHECK, DONE)
//   FLAGS_W   : width of the FPU status flag bundle
//   FLG_*     : bit positions inside {ine,overflow,underflow,inf,zero}
// -----------------------------------------------------------------------------
package fpu_chk_pkg;

    localparam int unsigned FLAGS_W = 5;

    localparam int unsigned FLG_INE  = 4;
    localparam int unsigned FLG_OVF  = 3;
    localparam int unsigned FLG_UNF  = 2;
    localparam int unsigned FLG_INF  = 1;
    localparam int unsigned FLG_ZERO = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage : fpu_chk_pkg

// File: rtl/fpu_chk_sat_cnt.sv
// -----------------------------------------------------------------------------
// fpu_chk_sat_cnt
// Saturating up-counter with synchronous clear (clear wins over increment).
//   clk_i : clock, rising edge
//   rst   : asynchronous active-high reset
//   clr   : synchronous clear to zero
//   inc   : increment by one, sticks at all-ones
//   cnt_o : current count
// -----------------------------------------------------------------------------
module fpu_chk_sat_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            cnt_o <= '0;
        end else if (clr) begin
            cnt_o <= '0;
        end else if (inc && (cnt_o != CNT_MAX)) begin
            cnt_o <= cnt_o + CNT_W'(1);
        end
    end

endmodule : fpu_chk_sat_cnt

// File: rtl/fpu_vector_checker.sv
// -----------------------------------------------------------------------------
// fpu_vector_checker
// Hardware fixed-latency checker for an FPU datapath. Accepts one test vector
// over a valid/ready stream, drives it onto the DUT, waits LATENCY cycles,
// compares the DUT result bit-exactly against the expected value and keeps
// saturating pass/fail/total counters plus a first-failure capture.
//
// Ports:
//   clk_i, RST            : clock (rising edge), async active-high reset
//   clear_i               : sync clear of counters/capture/done, back to IDLE
//   vec_valid_i/ready_o   : vector stream handshake
//   vec_opa/opb/op/mode_i : stimulus, vec_exp_i / vec_exp_flags_i : expected
//   vec_last_i            : marks the final vector of a run
//   dut_opa/opb/op/mode_o : held stimulus to the DUT
//   dut_result_i/flags_i  : DUT response
//   check_o, check_pass_o : comparison strobe and latest verdict
//   pass/fail/total_cnt_o : saturating counters
//   first_fail_*_o        : capture of the first failing vector
//   done_o                : last vector has been checked
//
// Build option FPU_CHK_FLAGS_EN: also require dut_flags_i to match the
// expected flags and add first_fail_flags_o. When undefined, both flag
// inputs are ignored.
// -----------------------------------------------------------------------------
module fpu_vector_checker
    import fpu_chk_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned OP_W    = 1,
    parameter int unsigned MODE_W  = 2,
    parameter int unsigned LATENCY = 10,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               RST,
    input  logic               clear_i,
    input  logic               vec_valid_i,
    output logic               vec_ready_o,
    input  logic [DATA_W-1:0]  vec_opa_i,
    input  logic [DATA_W-1:0]  vec_opb_i,
    input  logic [OP_W-1:0]    vec_op_i,
    input  logic [MODE_W-1:0]  vec_mode_i,
    input  logic [DATA_W-1:0]  vec_exp_i,
    input  logic [FLAGS_W-1:0] vec_exp_flags_i,
    input  logic               vec_last_i,
    output logic [DATA_W-1:0]  dut_opa_o,
    output logic [DATA_W-1:0]  dut_opb_o,
    output logic [OP_W-1:0]    dut_op_o,
    output logic [MODE_W-1:0]  dut_mode_o,
    input  logic [DATA_W-1:0]  dut_result_i,
    input  logic [FLAGS_W-1:0] dut_flags_i,
    output logic               check_o,
    output logic               check_pass_o,
    output logic [CNT_W-1:0]   pass_cnt_o,
    output logic [CNT_W-1:0]   fail_cnt_o,
    output logic [CNT_W-1:0]   total_cnt_o,
    output logic               first_fail_vld_o,
    output logic [CNT_W-1:0]   first_fail_idx_o,
    output logic [DATA_W-1:0]  first_fail_res_o,
`ifdef FPU_CHK_FLAGS_EN
    output logic [FLAGS_W-1:0] first_fail_flags_o,
`endif
    output logic               done_o
);

    // Wide enough to hold LATENCY-1
    localparam int unsigned WAIT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    state_e             state_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [DATA_W-1:0]  exp_q;
    logic               last_q;
    logic               pass_c;
    logic               do_check_c;

    // Verdict on the response sampled in CHECK
`ifdef FPU_CHK_FLAGS_EN
    logic [FLAGS_W-1:0] exp_flags_q;
    assign pass_c = (dut_result_i == exp_q) && (dut_flags_i == exp_flags_q);
`else
    logic unused_flags;
    assign unused_flags = ^{vec_exp_flags_i, dut_flags_i};
    assign pass_c       = (dut_result_i == exp_q);
`endif

    assign do_check_c = (state_q == CHECK);

    // Status counters; clear_i overrides any increment in the same cycle
    fpu_chk_sat_cnt #(.CNT_W(CNT_W)) u_total_cnt (
        .clk_i (clk_i),
        .rst   (RST),
        .clr   (clear_i),
        .inc   (do_check_c),
        .cnt_o (total_cnt_o)
    );

    fpu_chk_sat_cnt #(.CNT_W(CNT_W)) u_pass_cnt (
        .clk_i (clk_i),
        .rst   (RST),
        .clr   (clear_i),
        .inc   (do_check_c && pass_c),
        .cnt_o (pass_cnt_o)
    );

    fpu_chk_sat_cnt #(.CNT_W(CNT_W)) u_fail_cnt (
        .clk_i (clk_i),
        .rst   (RST),
        .clr   (clear_i),
        .inc   (do_check_c && !pass_c),
        .cnt_o (fail_cnt_o)
    );

    // Control FSM with registered outputs
    always_ff @(posedge clk_i or posedge RST) begin
        if (RST) begin
            state_q          <= IDLE;
            wait_q           <= '0;
            exp_q            <= '0;
            last_q           <= 1'b0;
            vec_ready_o      <= 1'b0;
            dut_opa_o        <= '0;
            dut_opb_o        <= '0;
            dut_op_o         <= '0;
            dut_mode_o       <= '0;
            check_o          <= 1'b0;
            check_pass_o     <= 1'b0;
            first_fail_vld_o <= 1'b0;
            first_fail_idx_o <= '0;
            first_fail_res_o <= '0;
            done_o           <= 1'b0;
`ifdef FPU_CHK_FLAGS_EN
            exp_flags_q        <= '0;
            first_fail_flags_o <= '0;
`endif
        end else if (clear_i) begin
            // Abort any in-flight vector; DUT drive is deliberately kept
            state_q          <= IDLE;
            last_q           <= 1'b0;
            vec_ready_o      <= 1'b1;
            check_o          <= 1'b0;
            check_pass_o     <= 1'b0;
            first_fail_vld_o <= 1'b0;
            first_fail_idx_o <= '0;
            first_fail_res_o <= '0;
            done_o           <= 1'b0;
`ifdef FPU_CHK_FLAGS_EN
            first_fail_flags_o <= '0;
`endif
        end else begin
            check_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    vec_ready_o <= 1'b1;
                    if (vec_valid_i && vec_ready_o) begin
                        dut_opa_o   <= vec_opa_i;
                        dut_opb_o   <= vec_opb_i;
                        dut_op_o    <= vec_op_i;
                        dut_mode_o  <= vec_mode_i;
                        exp_q       <= vec_exp_i;
                        last_q      <= vec_last_i;
                        vec_ready_o <= 1'b0;
                        wait_q      <= WAIT_W'(LATENCY - 1);
`ifdef FPU_CHK_FLAGS_EN
                        exp_flags_q <= vec_exp_flags_i;
`endif
                        state_q     <= (LATENCY == 1) ? CHECK : WAIT;
                    end
                end
                WAIT: begin
                    // Leaving on 1 puts the CHECK edge exactly LATENCY after accept
                    wait_q <= wait_q - WAIT_W'(1);
                    if (wait_q == WAIT_W'(1)) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    check_o      <= 1'b1;
                    check_pass_o <= pass_c;
                    if (!pass_c && !first_fail_vld_o) begin
                        first_fail_vld_o <= 1'b1;
                        first_fail_idx_o <= total_cnt_o;
                        first_fail_res_o <= dut_result_i;
`ifdef FPU_CHK_FLAGS_EN
                        first_fail_flags_o <= dut_flags_i;
`endif
                    end
                    if (last_q) begin
                        state_q     <= DONE;
                        done_o      <= 1'b1;
                        vec_ready_o <= 1'b0;
                    end else begin
                        state_q     <= IDLE;
                        vec_ready_o <= 1'b1;
                    end
                end
                DONE: begin
                    vec_ready_o <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule : fpu_vector_checker

// File: tb/tb_fpu_vector_checker.sv
// -----------------------------------------------------------------------------
// tb_fpu_vector_checker
// Self-checking bench for fpu_vector_checker. A stand-in DUT response is
// driven per vector (garbage until the cycle before sampling), and a
// behavioural model tracks counters, capture and handshake timing.
// -----------------------------------------------------------------------------
module tb_fpu_vector_checker;
    import fpu_chk_pkg::*;

    localparam int unsigned DW   = 32;
    localparam int unsigned OPW  = 1;
    localparam int unsigned MW   = 2;
    localparam int unsigned LAT  = 3;
    localparam int unsigned CW   = 3;
    localparam int          CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [DW-1:0]      opa;
        logic [DW-1:0]      opb;
        logic [OPW-1:0]     op;
        logic [MW-1:0]      mode;
        logic [DW-1:0]      exp;
        logic [FLAGS_W-1:0] expf;
        logic [DW-1:0]      res;
        logic [FLAGS_W-1:0] resf;
        logic               last;
    } vec_t;

    logic               clk_i = 1'b0;
    logic               RST = 1'b1;
    logic               clear_i = 1'b0;
    logic               vec_valid_i = 1'b0;
    logic               vec_ready_o;
    logic [DW-1:0]      vec_opa_i = '0;
    logic [DW-1:0]      vec_opb_i = '0;
    logic [OPW-1:0]     vec_op_i = '0;
    logic [MW-1:0]      vec_mode_i = '0;
    logic [DW-1:0]      vec_exp_i = '0;
    logic [FLAGS_W-1:0] vec_exp_flags_i = '0;
    logic               vec_last_i = 1'b0;
    logic [DW-1:0]      dut_opa_o;
    logic [DW-1:0]      dut_opb_o;
    logic [OPW-1:0]     dut_op_o;
    logic [MW-1:0]      dut_mode_o;
    logic [DW-1:0]      dut_result_i = '0;
    logic [FLAGS_W-1:0] dut_flags_i = '0;
    logic               check_o;
    logic               check_pass_o;
    logic [CW-1:0]      pass_cnt_o;
    logic [CW-1:0]      fail_cnt_o;
    logic [CW-1:0]      total_cnt_o;
    logic               first_fail_vld_o;
    logic [CW-1:0]      first_fail_idx_o;
    logic [DW-1:0]      first_fail_res_o;
`ifdef FPU_CHK_FLAGS_EN
    logic [FLAGS_W-1:0] first_fail_flags_o;
`endif
    logic               done_o;

    fpu_vector_checker #(
        .DATA_W (DW), .OP_W (OPW), .MODE_W (MW), .LATENCY (LAT), .CNT_W (CW)
    ) dut (
        .clk_i            (clk_i),
        .RST              (RST),
        .clear_i          (clear_i),
        .vec_valid_i      (vec_valid_i),
        .vec_ready_o      (vec_ready_o),
        .vec_opa_i        (vec_opa_i),
        .vec_opb_i        (vec_opb_i),
        .vec_op_i         (vec_op_i),
        .vec_mode_i       (vec_mode_i),
        .vec_exp_i        (vec_exp_i),
        .vec_exp_flags_i  (vec_exp_flags_i),
        .vec_last_i       (vec_last_i),
        .dut_opa_o        (dut_opa_o),
        .dut_opb_o        (dut_opb_o),
        .dut_op_o         (dut_op_o),
        .dut_mode_o       (dut_mode_o),
        .dut_result_i     (dut_result_i),
        .dut_flags_i      (dut_flags_i),
        .check_o          (check_o),
        .check_pass_o     (check_pass_o),
        .pass_cnt_o       (pass_cnt_o),
        .fail_cnt_o       (fail_cnt_o),
        .total_cnt_o      (total_cnt_o),
        .first_fail_vld_o (first_fail_vld_o),
        .first_fail_idx_o (first_fail_idx_o),
        .first_fail_res_o (first_fail_res_o),
`ifdef FPU_CHK_FLAGS_EN
        .first_fail_flags_o (first_fail_flags_o),
`endif
        .done_o           (done_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int                 m_pass, m_fail, m_total, m_ffi;
    bit                 m_ffv, m_lastpass, m_done, m_ready;
    logic [DW-1:0]      m_ffr;
    logic [FLAGS_W-1:0] m_fff;
    vec_t               m_dut;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    function automatic void model_clear();
        m_pass = 0; m_fail = 0; m_total = 0; m_ffi = 0;
        m_ffv = 0; m_lastpass = 0; m_done = 0; m_ready = 1;
        m_ffr = '0; m_fff = '0;
    endfunction

    function automatic void model_check(input vec_t v);
        bit p;
        p = (v.res == v.exp);
`ifdef FPU_CHK_FLAGS_EN
        p = p && (v.resf == v.expf);
`endif
        if (!p && !m_ffv) begin
            m_ffv = 1; m_ffi = m_total; m_ffr = v.res; m_fff = v.resf;
        end
        m_total = sat(m_total + 1);
        if (p) m_pass = sat(m_pass + 1);
        else   m_fail = sat(m_fail + 1);
        m_lastpass = p;
        m_done     = v.last;
        m_ready    = !v.last;
    endfunction

    task automatic chk_status(input string tag);
        chk({tag, ".pass_flag"}, 64'(check_pass_o), 64'(m_lastpass));
        chk({tag, ".pass_cnt"},  64'(pass_cnt_o),   64'(m_pass));
        chk({tag, ".fail_cnt"},  64'(fail_cnt_o),   64'(m_fail));
        chk({tag, ".total_cnt"}, 64'(total_cnt_o),  64'(m_total));
        chk({tag, ".ff_vld"},    64'(first_fail_vld_o), 64'(m_ffv));
        chk({tag, ".ff_idx"},    64'(first_fail_idx_o), 64'(m_ffi));
        chk({tag, ".ff_res"},    64'(first_fail_res_o), 64'(m_ffr));
`ifdef FPU_CHK_FLAGS_EN
        chk({tag, ".ff_flags"},  64'(first_fail_flags_o), 64'(m_fff));
`endif
        chk({tag, ".done"},      64'(done_o),       64'(m_done));
        chk({tag, ".ready"},     64'(vec_ready_o),  64'(m_ready));
        chk({tag, ".dut_ab"},    {dut_opa_o, dut_opb_o}, {m_dut.opa, m_dut.opb});
        chk({tag, ".dut_opm"},   64'({dut_op_o, dut_mode_o}), 64'({m_dut.op, m_dut.mode}));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ready"}, 64'(vec_ready_o), 64'(0));
        chk({tag, ".check"}, 64'({check_o, check_pass_o, done_o, first_fail_vld_o}), 64'(0));
        chk({tag, ".cnts"},  64'({pass_cnt_o, fail_cnt_o, total_cnt_o, first_fail_idx_o}), 64'(0));
        chk({tag, ".ffres"}, 64'(first_fail_res_o), 64'(0));
        chk({tag, ".dut"},   {dut_opa_o, dut_opb_o}, 64'(0));
        chk({tag, ".dutopm"}, 64'({dut_op_o, dut_mode_o}), 64'(0));
    endtask

    function automatic vec_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [OPW-1:0] op, input logic [DW-1:0] e,
                                input logic [FLAGS_W-1:0] ef, input logic [DW-1:0] r,
                                input logic [FLAGS_W-1:0] rf, input logic last);
        vec_t v;
        v.opa = a; v.opb = b; v.op = op; v.mode = '0; v.exp = e; v.expf = ef;
        v.res = r; v.resf = rf; v.last = last;
        return v;
    endfunction

    function automatic vec_t rnd_vec(input logic last);
        vec_t v;
        v.opa  = $urandom;
        v.opb  = $urandom;
        v.op   = OPW'($urandom_range(0, 1));
        v.mode = MW'($urandom_range(0, 3));
        v.exp  = $urandom;
        v.expf = FLAGS_W'($urandom_range(0, 31));
        v.res  = ($urandom_range(0, 3) == 0) ? (v.exp ^ (32'h1 << $urandom_range(0, 31))) : v.exp;
        v.resf = ($urandom_range(0, 3) == 0) ? FLAGS_W'($urandom_range(0, 31)) : v.expf;
        v.last = last;
        return v;
    endfunction

    // Present a vector from a negedge; returns at the negedge after acceptance
    task automatic accept(input vec_t v, input bit hold, output bit ok, output int acc_cyc);
        int n;
        bit rdy;
        n = 0; rdy = 0;
        vec_valid_i = 1'b1;
        vec_opa_i = v.opa; vec_opb_i = v.opb; vec_op_i = v.op; vec_mode_i = v.mode;
        vec_exp_i = v.exp; vec_exp_flags_i = v.expf; vec_last_i = v.last;
        dut_result_i = ~v.exp; dut_flags_i = ~v.expf;
        while (!rdy && n < 40) begin
            rdy = vec_ready_o;
            @(posedge clk_i);
            n++;
            @(negedge clk_i);
        end
        ok = rdy;
        acc_cyc = cyc;
        if (!rdy) chk("accept_timeout", 64'(0), 64'(1));
        else m_dut = v;
        if (!hold) begin
            // Inputs only need to hold until accepted
            vec_valid_i = 1'b0;
            vec_opa_i = $urandom; vec_opb_i = $urandom; vec_exp_i = $urandom;
            vec_op_i = ~v.op; vec_mode_i = ~v.mode; vec_last_i = ~v.last;
            vec_exp_flags_i = ~v.expf;
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v, input bit hold, output int acc_cyc);
        bit ok, early;
        accept(v, hold, ok, acc_cyc);
        if (!ok) return;
        early = 0;
        for (int k = 0; k < int'(LAT); k++) begin
            if (check_o) early = 1;
            // True response appears only just before the sampling edge
            if (k == int'(LAT) - 1) begin
                dut_result_i = v.res; dut_flags_i = v.resf;
            end
            @(negedge clk_i);
        end
        chk({tag, ".early_check"}, 64'(early), 64'(0));
        chk({tag, ".check_pulse"}, 64'(check_o), 64'(1));
        model_check(v);
        chk_status(tag);
    endtask

    initial begin
        vec_t v;
        vec_t vq[$];
        int   ac, ac_prev;
        bit   ok;

        m_dut = '0;
        model_clear();

        // Reset state
        #2;
        chk_all_zero("reset");
        @(negedge clk_i);
        @(negedge clk_i);
        RST = 1'b0;
        @(negedge clk_i);
        chk_status("post_reset");
        chk("post_reset.check", 64'(check_o), 64'(0));

        // Directed: passing add, failing sub, second failure, flag-only mismatch
        run_vec("add_pass", mk(32'h3f800000, 32'h3f800000, 1'b0, 32'h40000000, 5'b00000,
                               32'h40000000, 5'b00000, 1'b0), 1'b0, ac);
        run_vec("sub_fail", mk(32'h40400000, 32'h3f800000, 1'b1, 32'h40000000, 5'b00000,
                               32'h40000001, 5'b00000, 1'b0), 1'b0, ac);
        run_vec("fail2", mk(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 5'b00000,
                            32'h40800002, 5'b00000, 1'b0), 1'b0, ac);
        run_vec("flags", mk(32'h3f800000, 32'hbf800000, 1'b0, 32'h00000000, 5'b00001,
                            32'h00000000, 5'b00000, 1'b0), 1'b0, ac);

        // Randomized vectors; drives counters into saturation
        for (int i = 0; i < 14; i++) begin
            run_vec("rnd", rnd_vec(1'b0), 1'b0, ac);
        end

        // Clear while idle, then flag-only mismatch again from a clean slate
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        model_clear();
        chk_status("clr_idle");
        run_vec("flags2", mk(32'h3f800000, 32'hbf800000, 1'b0, 32'h00000000, 5'b00001,
                             32'h00000000, 5'b00000, 1'b0), 1'b0, ac);

        // Clear during WAIT aborts the vector without counting it
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        model_clear();
        v = rnd_vec(1'b0);
        accept(v, 1'b0, ok, ac);
        @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        chk("clr_wait.check", 64'(check_o), 64'(0));
        chk_status("clr_wait");
        begin
            bit seen;
            seen = 0;
            dut_result_i = v.exp;
            for (int k = 0; k < int'(LAT) + 2; k++) begin
                if (check_o) seen = 1;
                @(negedge clk_i);
            end
            chk("clr_wait.no_check", 64'(seen), 64'(0));
            chk("clr_wait.total", 64'(total_cnt_o), 64'(0));
        end

        // Back-to-back with valid held high, last on the 4th
        for (int i = 0; i < 4; i++) vq.push_back(rnd_vec(i == 3));
        ac_prev = 0;
        for (int i = 0; i < 4; i++) begin
            run_vec("b2b", vq[i], 1'b1, ac);
            if (i > 0) chk("b2b.spacing", 64'(ac - ac_prev), 64'(LAT + 1));
            ac_prev = ac;
        end
        for (int k = 0; k < 4; k++) @(negedge clk_i);
        chk_status("done_hold");
        chk("done_hold.total", 64'(total_cnt_o), 64'(4));
        vec_valid_i = 1'b0;

        // Clear out of DONE
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        model_clear();
        chk_status("clr_done");

        // Reset asserted mid-WAIT acts immediately
        run_vec("pre_rst", rnd_vec(1'b0), 1'b0, ac);
        accept(rnd_vec(1'b0), 1'b0, ok, ac);
        @(negedge clk_i);
        RST = 1'b1;
        #1;
        chk_all_zero("rst_wait");
        @(negedge clk_i);
        RST = 1'b0;
        m_dut = '0;
        model_clear();
        @(negedge clk_i);
        chk_status("rst_release");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_fpu_vector_checker

// File: doc/fpu_vector_checker.md
Name: fpu_vector_checker

Overview:
Synthesizable, parametrised self-checking harness for FPU datapaths. Accepts test vectors (opa, opb, op, mode, expected) over a valid/ready stream and drives them onto a DUT such as FPU_32b. It waits a fixed DUT latency, compares the result bit-exactly against the expected value, and keeps pass/fail/total counters plus a first-failure capture. This moves file-driven fixed-wait checking into hardware for FPGA bring-up and long regression runs; generalised in width, op/mode width, latency and stream handshake.

Parameters:
DATA_W, 32, operand/result width
OP_W, 1, fpu_op width
MODE_W, 2, rounding-mode width
LATENCY, 10, cycles from DUT input change to result sampling (>=1)
CNT_W, 16, counter width (saturating)

Ports:
clk_i  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
clear_i  in  1  sync pulse: zero counters/capture, leave DONE, return to IDLE
vec_valid_i  in  1  vector present
vec_ready_o  out  1  checker can accept vector
vec_opa_i  in  DATA_W  operand A
vec_opb_i  in  DATA_W  operand B
vec_op_i  in  OP_W  operation code
vec_mode_i  in  MODE_W  rounding mode
vec_exp_i  in  DATA_W  expected result
vec_exp_flags_i  in  5  expected {ine,overflow,underflow,inf,zero}
vec_last_i  in  1  final vector of run
dut_opa_o / dut_opb_o  out  DATA_W  to DUT
dut_op_o  out  OP_W  to DUT
dut_mode_o  out  MODE_W  to DUT
dut_result_i  in  DATA_W  from DUT
dut_flags_i  in  5  from DUT {ine,overflow,underflow,inf,zero}
check_o  out  1  one-cycle pulse: comparison done
check_pass_o  out  1  result of latest comparison (valid with check_o, held)
pass_cnt_o / fail_cnt_o / total_cnt_o  out  CNT_W  counters
first_fail_vld_o  out  1  a failure has been captured
first_fail_idx_o  out  CNT_W  total_cnt value of first failing vector (0-based)
first_fail_res_o  out  DATA_W  DUT result of first failing vector
done_o  out  1  last vector checked

Behaviour:
- Reset (RST=1, async): state IDLE; every output 0 (dut_* = 0, counters 0, flags 0, vec_ready_o 0 while RST, 1 in IDLE after release).
- FSM IDLE -> WAIT -> CHECK -> IDLE|DONE.
- IDLE: vec_ready_o=1. Handshake at edge T when valid&ready: register vector into dut_* outputs and expected regs, latch last flag, load wait counter = LATENCY-1, go WAIT. Inputs must stay stable only until accepted.
- WAIT: vec_ready_o=0; counter decrements each cycle; at 0 go CHECK. dut_* held stable throughout.
- CHECK (edge T+LATENCY): sample dut_result_i; pass = (dut_result_i == exp). check_o pulses for one cycle, check_pass_o updated, total_cnt+1, pass_cnt or fail_cnt +1. If fail and !first_fail_vld: capture idx (pre-increment total) and result, set first_fail_vld_o. Next state DONE if last latched, else IDLE.
- Throughput: one vector per LATENCY+1 cycles; one vector in flight only.
- DONE: done_o=1, vec_ready_o=0, all status held; exits only via clear_i or RST.
- Counters saturate at 2^CNT_W-1; saturation does not block checking.
- clear_i takes priority over all states: counters, capture, check_pass_o, done_o cleared, aborts in-flight vector (no count), state IDLE next cycle; dut_* retained.
- RST mid-operation: immediate abort, all outputs to reset values.
- LATENCY=1: WAIT skipped (IDLE -> CHECK directly).

Optional Feature:
FPU_CHK_FLAGS_EN: when defined, pass additionally requires dut_flags_i == latched vec_exp_flags_i; also adds output first_fail_flags_o[4:0] capturing DUT flags of first failure. Undefined: vec_exp_flags_i and dut_flags_i ignored, compare on result only, no extra port.

Decomposition:
- Package fpu_chk_pkg: state enum (IDLE, WAIT, CHECK, DONE), flag bit index constants (FLG_INE=4 ... FLG_ZERO=0), FLAGS_W=5.
- One sub-module natural: fpu_chk_sat_cnt (CNT_W saturating counter with clear and inc), instantiated three times.

Test Plan:
- Reset then vector 3f800000+3f800000 op0 exp 40000000, DUT model correct -> check_o at accept+LATENCY, pass_cnt=1, total=1, check_pass_o=1.
- Vector 40400000 - 3f800000 op1 exp 40000000, DUT returns 40000001 -> fail_cnt=1, first_fail_vld_o=1, idx=0, res=40000001; second failure leaves capture unchanged.
- 4 back-to-back vectors, valid held high, last on 4th -> accepts spaced LATENCY+1 cycles, total=4, done_o=1, vec_ready_o=0 after.
- clear_i asserted during WAIT -> no counter increment, IDLE next cycle, ready=1, counters 0.
- RST asserted mid-WAIT -> all outputs 0 asynchronously; CNT_W=2 with 5 passing vectors -> pass_cnt saturates at 3.
- With FPU_CHK_FLAGS_EN: result match, exp flags 00001 vs DUT 00000 -> fail, first_fail_flags_o=00000; without macro same vector -> pass.
